// File: rtl/alu_mdu.sv
// Execute-stage ALU with registered outputs and iterative multiply/divide.
// Single-cycle ops complete in one cycle; mul/div take WIDTH steps behind a valid/ready handshake.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] src_A,
    input  logic [WIDTH-1:0] src_B,
    input  logic [3:0]       ALU_control,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] ALU_result,
    output logic             zero,
    output logic             valid_out
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     op_q, op_d;
    logic                 hi_q, hi_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 valid_q, valid_d;

    logic [SHAMT_W-1:0]   shamt;
    logic [WIDTH-1:0]     alu_res;
    logic [WIDTH-1:0]     mul_addend;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_trial;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;

    // Single-cycle results straight from the live inputs.
    always_comb begin
        alu_res = '0;
        shamt   = src_B[SHAMT_W-1:0];
        case (ALU_control)
            OP_ADD:  alu_res = src_A + src_B;
            OP_SUB:  alu_res = src_A - src_B;
            OP_AND:  alu_res = src_A & src_B;
            OP_OR:   alu_res = src_A | src_B;
            OP_XOR:  alu_res = src_A ^ src_B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_A) < $signed(src_B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_A < src_B)};
            OP_SLL:  alu_res = src_A << shamt;
            OP_SRL:  alu_res = src_A >> shamt;
            OP_SRA:  alu_res = $signed(src_A) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // One iteration step of each unit. MUL keeps the multiplier in acc low half and shifts right;
    // DIV keeps {remainder, dividend/quotient} in acc and shifts left. Divide by zero falls out naturally.
    always_comb begin
        mul_addend = acc_q[0] ? op_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

        div_trial  = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge     = (div_trial >= {1'b0, op_q});
        div_rem    = div_ge ? (div_trial[WIDTH-1:0] - op_q) : div_trial[WIDTH-1:0];
        div_next   = {div_rem, acc_q[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            hi_q     <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        op_d     = op_q;
        hi_d     = hi_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    case (ALU_control)
                        OP_MUL, OP_MULHU: begin
                            state_d = MUL;
                            cnt_d   = CNT_W'(WIDTH);
                            acc_d   = {{WIDTH{1'b0}}, src_B};
                            op_d    = src_A;
                            hi_d    = (ALU_control == OP_MULHU);
                        end
                        OP_DIVU, OP_REMU: begin
                            state_d = DIV;
                            cnt_d   = CNT_W'(WIDTH);
                            acc_d   = {{WIDTH{1'b0}}, src_A};
                            op_d    = src_B;
                            hi_d    = (ALU_control == OP_REMU);
                        end
                        default: begin
                            result_d = alu_res;
                            valid_d  = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                acc_d = mul_next;
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = IDLE;
                    result_d = hi_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
                    valid_d  = 1'b1;
                end
            end
            DIV: begin
                cnt_d = cnt_q - CNT_W'(1);
                acc_d = div_next;
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = IDLE;
                    result_d = hi_q ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
                    valid_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    always_comb begin
        ready_out  = (state_q == IDLE);
        ALU_result = result_q;
        zero       = zero_q;
        valid_out  = valid_q;
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (WIDTH=32) with hand-computed expected values.
module tb_alu_mdu;

    logic        clock;
    logic        reset_n;
    logic [31:0] src_A;
    logic [31:0] src_B;
    logic [3:0]  ALU_control;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] ALU_result;
    logic        zero;
    logic        valid_out;

    int vectors    = 0;
    int miscompares = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .src_A       (src_A),
        .src_B       (src_B),
        .ALU_control (ALU_control),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .ALU_result  (ALU_result),
        .zero        (zero),
        .valid_out   (valid_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one op for a single accept edge, scrambles the inputs afterwards, then waits for valid_out.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output int rlow);
        ALU_control = op;
        src_A       = a;
        src_B       = b;
        valid_in    = 1'b1;
        @(posedge clock);
        #1;
        valid_in    = 1'b0;
        src_A       = ~a;
        src_B       = ~b;
        ALU_control = 4'b0000;
        lat  = 1;
        rlow = 0;
        while (!valid_out && lat < 200) begin
            if (!ready_out) rlow++;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int rlow;
        int pulses;
        int first_lat;
        logic [31:0] first_res;

        reset_n     = 1'b0;
        valid_in    = 1'b0;
        src_A       = '0;
        src_B       = '0;
        ALU_control = 4'b0000;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_result", ALU_result, 32'h0);
        checkOutput("reset_zero",   zero,       1'b1);
        checkOutput("reset_valid",  valid_out,  1'b0);
        checkOutput("reset_ready",  ready_out,  1'b1);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        applyStimulus(4'b0000, 32'hFFFF_FFFF, 32'h1, lat, rlow);
        checkOutput("add_wrap_res",  ALU_result, 32'h0);
        checkOutput("add_wrap_zero", zero,       1'b1);
        checkOutput("add_wrap_lat",  lat,        1);
        @(posedge clock);
        #1;
        checkOutput("add_wrap_pulse", valid_out, 1'b0);

        applyStimulus(4'b0101, 32'hFFFF_FFFF, 32'h1, lat, rlow);
        checkOutput("slt_res",  ALU_result, 32'h1);
        checkOutput("slt_zero", zero,       1'b0);
        applyStimulus(4'b0110, 32'hFFFF_FFFF, 32'h1, lat, rlow);
        checkOutput("sltu_res", ALU_result, 32'h0);
        applyStimulus(4'b1001, 32'h8000_0000, 32'h21, lat, rlow);
        checkOutput("sra_res", ALU_result, 32'hC000_0000);
        applyStimulus(4'b1000, 32'h8000_0000, 32'h1F, lat, rlow);
        checkOutput("srl_res", ALU_result, 32'h1);
        applyStimulus(4'b1111, 32'h1234_5678, 32'h1, lat, rlow);
        checkOutput("reserved_res",  ALU_result, 32'h0);
        checkOutput("reserved_zero", zero,       1'b1);

        applyStimulus(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rlow);
        checkOutput("mul_res",   ALU_result, 32'h1);
        checkOutput("mul_lat",   lat,        33);
        checkOutput("mul_rlow",  rlow,       32);
        checkOutput("mul_ready", ready_out,  1'b1);
        applyStimulus(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rlow);
        checkOutput("mulhu_res",  ALU_result, 32'hFFFF_FFFE);
        checkOutput("mulhu_lat",  lat,        33);
        checkOutput("mulhu_rlow", rlow,       32);

        applyStimulus(4'b1100, 32'd100, 32'd7, lat, rlow);
        checkOutput("divu_res", ALU_result, 32'd14);
        checkOutput("divu_lat", lat,        33);
        applyStimulus(4'b1101, 32'd100, 32'd7, lat, rlow);
        checkOutput("remu_res", ALU_result, 32'd2);
        checkOutput("remu_lat", lat,        33);
        applyStimulus(4'b1100, 32'd5, 32'd0, lat, rlow);
        checkOutput("divu0_res", ALU_result, 32'hFFFF_FFFF);
        checkOutput("divu0_lat", lat,        33);
        applyStimulus(4'b1101, 32'd5, 32'd0, lat, rlow);
        checkOutput("remu0_res", ALU_result, 32'd5);
        checkOutput("remu0_lat", lat,        33);

        // Abort a divide with reset in its tenth cycle.
        ALU_control = 4'b1100;
        src_A       = 32'd1000;
        src_B       = 32'd3;
        valid_in    = 1'b1;
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        reset_n = 1'b0;
        #1;
        checkOutput("abort_result", ALU_result, 32'h0);
        checkOutput("abort_zero",   zero,       1'b1);
        checkOutput("abort_valid",  valid_out,  1'b0);
        checkOutput("abort_ready",  ready_out,  1'b1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        pulses  = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (valid_out) pulses++;
            @(posedge clock);
            #1;
        end
        checkOutput("abort_no_valid", pulses,    0);
        checkOutput("abort_ready_after", ready_out, 1'b1);
        applyStimulus(4'b0000, 32'd2, 32'd3, lat, rlow);
        checkOutput("post_reset_add", ALU_result, 32'd5);

        // Five single-cycle ops accepted on consecutive edges.
        ALU_control = 4'b0001; src_A = 32'd10;          src_B = 32'd3;          valid_in = 1'b1;
        @(posedge clock); #1;
        checkOutput("b2b_sub_valid", valid_out, 1'b1);
        checkOutput("b2b_sub_res",   ALU_result, 32'd7);
        ALU_control = 4'b0010; src_A = 32'hF0F0_F0F0;   src_B = 32'h0FF0_0FF0;
        @(posedge clock); #1;
        checkOutput("b2b_and_valid", valid_out, 1'b1);
        checkOutput("b2b_and_res",   ALU_result, 32'h00F0_00F0);
        ALU_control = 4'b0011; src_A = 32'h1234_0000;   src_B = 32'h0000_5678;
        @(posedge clock); #1;
        checkOutput("b2b_or_valid", valid_out, 1'b1);
        checkOutput("b2b_or_res",   ALU_result, 32'h1234_5678);
        ALU_control = 4'b0100; src_A = 32'hFFFF_0000;   src_B = 32'h0F0F_0F0F;
        @(posedge clock); #1;
        checkOutput("b2b_xor_valid", valid_out, 1'b1);
        checkOutput("b2b_xor_res",   ALU_result, 32'hF0F0_0F0F);
        ALU_control = 4'b0111; src_A = 32'h1;           src_B = 32'h24;
        @(posedge clock); #1;
        valid_in = 1'b0;
        checkOutput("b2b_sll_valid", valid_out, 1'b1);
        checkOutput("b2b_sll_res",   ALU_result, 32'h10);
        @(posedge clock); #1;
        checkOutput("b2b_end_valid", valid_out, 1'b0);

        // An add offered during a multiply must be dropped.
        ALU_control = 4'b1010;
        src_A       = 32'd6;
        src_B       = 32'd7;
        valid_in    = 1'b1;
        @(posedge clock);
        #1;
        valid_in  = 1'b0;
        pulses    = 0;
        first_lat = 0;
        first_res = '0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            if (valid_out) begin
                pulses++;
                if (pulses == 1) begin
                    first_lat = cyc;
                    first_res = ALU_result;
                end
            end
            if (cyc == 5) begin
                ALU_control = 4'b0000;
                src_A       = 32'd1;
                src_B       = 32'd1;
                valid_in    = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            @(posedge clock);
            #1;
        end
        checkOutput("ignore_pulses", pulses,    1);
        checkOutput("ignore_lat",    first_lat, 33);
        checkOutput("ignore_res",    first_res, 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised successor to the CPU's combinational ALU. It adds registered outputs, unsigned compare, shifts, and iterative multiply/divide, behind a valid/ready handshake. It sits in the execute stage and is shared by ALU and M-type instructions. The stage must stall on ready_out low.

Parameters:
WIDTH, 32, datapath width in bits; must be a power of 2 and at least 8.
SHAMT_W, $clog2(WIDTH), number of low src_B bits used as the shift amount (derived; do not override).

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
src_A  input  WIDTH  operand A.
src_B  input  WIDTH  operand B.
ALU_control  input  4  operation select.
valid_in  input  1  operands and ALU_control are valid this cycle.
ready_out  output  1  block can accept an operation this cycle.
ALU_result  output  WIDTH  registered result.
zero  output  1  registered flag: (ALU_result == 0).
valid_out  output  1  one-cycle pulse; ALU_result and zero are new this cycle.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset values: state IDLE, ALU_result 0, zero 1, valid_out 0, ready_out 1, counter 0.
- Acceptance: an operation is accepted on a rising edge where valid_in && ready_out. Operands and opcode are latched at that edge; later input changes are ignored.
- ALU_control decode, single-cycle class:
  - 0000 add; 0001 sub (both modulo 2^WIDTH).
  - 0010 and; 0011 or; 0100 xor.
  - 0101 slt (signed); 0110 sltu (unsigned). Result is 1 or 0, zero-extended.
  - 0111 sll; 1000 srl; 1001 sra. Shift amount is src_B[SHAMT_W-1:0]; upper bits of src_B are ignored.
  - 1110, 1111 reserved: result 0, treated as single-cycle.
- ALU_control decode, multi-cycle class:
  - 1010 mul: low WIDTH bits of unsigned product.
  - 1011 mulhu: high WIDTH bits of unsigned product.
  - 1100 divu: unsigned quotient.
  - 1101 remu: unsigned remainder.
- States: IDLE, MUL, DIV.
  - IDLE: ready_out = 1.
  - Single-cycle op accepted: stay in IDLE. Result is registered at the accepting edge; valid_out = 1 the following cycle (latency 1). Back-to-back accepts every cycle are allowed, giving one result per cycle.
  - mul/mulhu accepted: go to MUL. divu/remu accepted: go to DIV. Counter loads WIDTH; ready_out = 0 while in MUL or DIV.
- MUL: shift-add, one bit of src_B per cycle, 2*WIDTH-bit accumulator. Counter decrements each cycle.
- DIV: restoring divide, one quotient bit per cycle. Counter decrements each cycle.
- Multi-cycle completion: on the edge where the counter reaches 0, write ALU_result and zero, return to IDLE. valid_out pulses the following cycle. Total latency from accept to valid_out is WIDTH+1 cycles; the next accept is possible in the valid_out cycle.
- Divide by zero (src_B == 0): divu returns all ones; remu returns src_A. Still takes the full WIDTH+1 latency.
- Output hold: valid_out is a single-cycle pulse with no output backpressure. ALU_result and zero hold their last values until the next completion.
- valid_in while ready_out == 0: ignored; the operation is not queued.
- Reset asserted mid-operation: operation aborted immediately, all outputs take reset values, no valid_out is produced for it.
- zero: always equals (ALU_result == 0), updated on the same edge as ALU_result.

Test Plan:
- Add wrap (WIDTH=32): add 0xFFFFFFFF + 1 → ALU_result 0, zero 1, valid_out exactly 1 cycle after accept.
- Compare: slt 0xFFFFFFFF vs 1 → 1; sltu with the same operands → 0. sra 0x80000000 by src_B=0x21 (shamt 1) → 0xC0000000.
- Multiply: mul 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001; mulhu with the same operands → 0xFFFFFFFE. Each has valid_out exactly 33 cycles after accept and ready_out low for 32 cycles.
- Divide: divu 100/7 → 14; remu 100/7 → 2; divu 5/0 → 0xFFFFFFFF; remu 5/0 → 5. Each takes 33-cycle latency.
- Reset mid-divide: assert reset_n=0 at cycle 10 of divu → outputs immediately reset, ready_out 1 after release, no valid_out for the aborted op. A following add 2+3 → 5.
- Throughput/ignore: five consecutive single-cycle ops → five consecutive valid_out pulses with correct results. valid_in asserted during a mul → ignored, only the mul result appears.
